uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, next generation of the core's simple RX path. Data width, parity and stop-bit count are configurable. Bits are sampled by majority vote around each bit centre, false starts are rejected, and framing/parity/overrun errors are reported. Output is a valid/ready register slice feeding the core's MMIO input queue.

Parameters:
- CLK_PER_BIT, 16, clk cycles per UART bit; legal range ≥ 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, number of stop bits: 1 or 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high; clock clk.
- rxd  in  1  asynchronous serial input; idle level high.
- rdata  out  DATA_BITS  received word, LSB first on the line.
- rvalid  out  1  rdata/ferr/perr valid; held until accepted.
- rready  in  1  consumer accepts the word when rvalid && rready.
- ferr  out  1  framing error: a stop bit sampled 0.
- perr  out  1  parity mismatch; always 0 when PARITY = 0.
- ovf  out  1  sticky overrun flag.
- brk  out  1  break detected; see Optional Feature.

Behaviour:
- Reset values: rdata = 0, rvalid = 0, ferr = 0, perr = 0, ovf = 0, brk = 0. Synchroniser resets to all 1s. State = IDLE.
- Synchroniser: 3-flop chain (ASYNC_REG). rxs is the last stage.
- Bit counter: width $clog2(CLK_PER_BIT). Mid-bit index M = CLK_PER_BIT/2.
- Sampling: each bit samples rxs at counter values M-1, M and M+1. The bit value is the majority of the three (2-of-3).
- IDLE -> START on the first cycle rxs = 0; the counter is cleared.
- START:
  - At M+1, if the voted value is 1 it is a false start -> IDLE, with no output and no flags.
  - Otherwise continue counting.
  - At CLK_PER_BIT-1 -> DATA with the counter cleared.
- DATA:
  - Shift the voted bit in LSB first at counter M+1.
  - Leave after DATA_BITS bits: -> PARITY if PARITY != 0, else -> STOP.
- PARITY: one bit.
  - perr_n = voted bit XOR (odd: ~^data; even: ^data), i.e. the computed parity of data plus the parity bit must be odd / even respectively.
- STOP: STOP_BITS bits.
  - ferr_n is set if any stop bit votes 0.
  - At M+1 of the last stop bit the frame completes and the FSM goes -> IDLE immediately (half-bit early, to resync on back-to-back frames).
- Completion cycle, when rvalid = 0 or (rvalid && rready):
  - Load rdata, ferr and perr.
  - rvalid = 1 on the next cycle.
  - Frames with ferr or perr are still delivered.
- Completion cycle, when rvalid && !rready:
  - The new frame is dropped; rdata, ferr and perr are kept.
  - ovf is set to 1.
- Handshake:
  - rvalid falls in the cycle after rvalid && rready, unless a frame completes in that same cycle. In that case rvalid stays 1 and the new data is loaded.
  - ovf is cleared on any accepted handshake, unless it is set in the same cycle (set wins).
- Latency: rvalid rises 1 cycle after the M+1 sample of the last stop bit. Counted from the rxd start edge, that is about (1 + DATA_BITS + P + STOP_BITS - 0.5) * CLK_PER_BIT + 4 cycles, where P = 1 if PARITY != 0, else 0.
- Reset mid-frame: everything returns to reset values; the partial frame is discarded; no rvalid.
- rready while rvalid = 0 has no effect.

Optional Feature:
- Macro: UART_RX_BREAK_EN.
- Defined:
  - A frame with all data bits 0, parity (if present) 0 and first stop bit 0 is a break.
  - The break is delivered as rdata = 0, ferr = 1, brk = 1 through the normal handshake.
  - The FSM then enters BRK_WAIT and holds until rxs = 1 for one full CLK_PER_BIT before returning to IDLE.
  - No false frames are produced during the line-low period.
- Undefined: brk is tied to 0. A break gives one frame with rdata = 0 and ferr = 1, then normal IDLE start detection, which can give repeated ferr frames while the line stays low.

Test Plan:
- CLK_PER_BIT = 16, 8N1; send 0xA5, rready = 1 -> one rvalid pulse, rdata = 0xA5, ferr = 0, perr = 0, ovf = 0.
- rxd low for 3 cycles, then high -> no rvalid; FSM back in IDLE; a following 0x3C frame is received correctly.
- PARITY = 2, send 0x07 with parity bit 0 (correct is 1) -> rdata = 0x07, perr = 1; send 0x07 with parity 1 -> perr = 0.
- Send 0x55 with stop bit 0 -> rdata = 0x55, ferr = 1. Single-cycle glitch at the mid-bit of data bit 3 -> 0x55 still received (majority vote).
- rready = 0; send 0x11 then 0x22 -> rdata = 0x11, ovf = 1. After the rready handshake, ovf = 0 and rvalid = 0.
- Assert rst at data bit 4 of a frame -> all outputs 0, no rvalid. Next frame 0x81 is received correctly. With UART_RX_BREAK_EN, rxd held low for 30 bit times -> exactly one rvalid with brk = 1, rdata = 0, ferr = 1.

Source files
------------

// File: rtl/uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_cfg
// Purpose  : Parametrised UART receiver. It has a 3-flop input synchroniser and
//            takes each bit as the 2-of-3 majority of samples around the bit
//            centre. It rejects false starts and reports framing, parity and
//            overrun errors. A valid/ready register slice drives the output.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   CLK_PER_BIT  clk cycles per UART bit (>= 4)
//   DATA_BITS    data bits per frame (5..9)
//   PARITY       0 = none, 1 = odd, 2 = even
//   STOP_BITS    1 or 2
// Ports:
//   clk     in   clock
//   rst     in   synchronous active-high reset
//   rxd     in   asynchronous serial input, idle high
//   rdata   out  received word (LSB first on the line)
//   rvalid  out  rdata/ferr/perr/brk valid, held until accepted
//   rready  in   consumer accepts when rvalid && rready
//   ferr    out  framing error (a stop bit voted 0)
//   perr    out  parity mismatch (always 0 when PARITY = 0)
//   ovf     out  sticky overrun, cleared by an accepted handshake
//   brk     out  break detected (0 unless UART_RX_BREAK_EN)
// Build option:
//   UART_RX_BREAK_EN  a frame that is all zeros, including the first stop bit,
//                     is delivered once with brk = 1. The receiver then waits
//                     for one full idle bit before it looks for a new start.
// ============================================================================
module uart_rx_cfg #(
   parameter int CLK_PER_BIT = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rdata,
   output logic                 rvalid,
   input  logic                 rready,
   output logic                 ferr,
   output logic                 perr,
   output logic                 ovf,
   output logic                 brk
);

   localparam int CW  = $clog2(CLK_PER_BIT);
   localparam int MID = CLK_PER_BIT / 2;

   localparam logic [CW-1:0] C_SMP0  = CW'(MID - 1);
   localparam logic [CW-1:0] C_SMP1  = CW'(MID);
   localparam logic [CW-1:0] C_SMP2  = CW'(MID + 1);
   localparam logic [CW-1:0] C_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [3:0]    C_DLAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    C_SLAST = 4'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_PAR   = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_RX_BREAK_EN
   localparam logic [2:0] S_BRKW  = 3'd5;
`endif

   (* ASYNC_REG = "TRUE" *) logic [2:0] sync_q;
   logic [2:0]           sync_d;
   logic [2:0]           state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [1:0]           vote_q, vote_d;
   logic [3:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 perr_f_q, perr_f_d;
   logic                 ferr_f_q, ferr_f_d;
   logic [DATA_BITS-1:0] rdata_q, rdata_d;
   logic                 rvalid_q, rvalid_d;
   logic                 ferr_q, ferr_d;
   logic                 perr_q, perr_d;
   logic                 ovf_q, ovf_d;
   logic                 rxs, voted, complete;
`ifdef UART_RX_BREAK_EN
   logic                 par0_q, par0_d;
   logic                 stop0_q, stop0_d;
   logic                 brk_q, brk_d;
   logic                 frame_brk;
`endif

   assign rxs = sync_q[2];
   // The two earlier samples are registered. The third sample (at M+1) is the
   // live synchroniser output, so the voted bit is available in the M+1 cycle.
   assign voted = (vote_q[0] & vote_q[1]) | (vote_q[0] & rxs) | (vote_q[1] & rxs);

   always_comb begin
      sync_d   = {sync_q[1:0], rxd};
      state_d  = state_q;
      cnt_d    = (cnt_q == C_LAST) ? '0 : cnt_q + 1'b1;
      vote_d   = vote_q;
      bit_d    = bit_q;
      shreg_d  = shreg_q;
      perr_f_d = perr_f_q;
      ferr_f_d = ferr_f_q;
      rdata_d  = rdata_q;
      rvalid_d = rvalid_q;
      ferr_d   = ferr_q;
      perr_d   = perr_q;
      ovf_d    = ovf_q;
      complete = 1'b0;
`ifdef UART_RX_BREAK_EN
      par0_d    = par0_q;
      stop0_d   = stop0_q;
      brk_d     = brk_q;
      frame_brk = 1'b0;
`endif

      if (cnt_q == C_SMP0) vote_d[0] = rxs;
      if (cnt_q == C_SMP1) vote_d[1] = rxs;

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (!rxs) begin
               state_d  = S_START;
               bit_d    = '0;
               ferr_f_d = 1'b0;
               perr_f_d = 1'b0;
            end
         end
         S_START: begin
            // The false-start test comes first. When CLK_PER_BIT = 4, M+1 and
            // the last count are the same cycle.
            if (cnt_q == C_SMP2 && voted) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == C_LAST) begin
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (cnt_q == C_SMP2) shreg_d = {voted, shreg_q[DATA_BITS-1:1]};
            if (cnt_q == C_LAST) begin
               if (bit_q == C_DLAST) begin
                  bit_d   = '0;
                  state_d = (PARITY != 0) ? S_PAR : S_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_PAR: begin
            if (cnt_q == C_SMP2) begin
               // Odd: the word plus the parity bit must hold an odd number of
               // ones. Even: an even number.
               perr_f_d = (PARITY == 1) ? ~(voted ^ (^shreg_q)) : (voted ^ (^shreg_q));
`ifdef UART_RX_BREAK_EN
               par0_d = voted;
`endif
            end
            if (cnt_q == C_LAST) state_d = S_STOP;
         end
         S_STOP: begin
            if (cnt_q == C_SMP2) begin
               ferr_f_d = ferr_f_q | ~voted;
`ifdef UART_RX_BREAK_EN
               if (bit_q == '0) stop0_d = voted;
`endif
               if (bit_q == C_SLAST) begin
                  // Leave half a bit early so the next start edge is not missed.
                  complete = 1'b1;
                  state_d  = S_IDLE;
                  cnt_d    = '0;
`ifdef UART_RX_BREAK_EN
                  frame_brk = (shreg_q == '0) && ((PARITY == 0) || !par0_q) &&
                              !((bit_q == '0) ? voted : stop0_q);
                  if (frame_brk) state_d = S_BRKW;
`endif
               end
            end
            if (cnt_q == C_LAST && bit_q != C_SLAST) bit_d = bit_q + 1'b1;
         end
`ifdef UART_RX_BREAK_EN
         S_BRKW: begin
            // Stay here until rxs has been high for a full bit.
            if (!rxs) cnt_d = '0;
            else if (cnt_q == C_LAST) state_d = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

      // Output slice. A frame that completes in the same cycle as a
      // handshake replaces the accepted word, so rvalid stays high.
      if (complete && (!rvalid_q || rready)) begin
         rdata_d  = shreg_q;
         ferr_d   = ferr_f_q | ~voted;
         perr_d   = perr_f_q;
         rvalid_d = 1'b1;
`ifdef UART_RX_BREAK_EN
         brk_d = frame_brk;
`endif
      end else if (rvalid_q && rready) begin
         rvalid_d = 1'b0;
      end

      if (complete && rvalid_q && !rready) ovf_d = 1'b1;
      else if (rvalid_q && rready) ovf_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q   <= 3'b111;
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         vote_q   <= '0;
         bit_q    <= '0;
         shreg_q  <= '0;
         perr_f_q <= 1'b0;
         ferr_f_q <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         perr_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         vote_q   <= vote_d;
         bit_q    <= bit_d;
         shreg_q  <= shreg_d;
         perr_f_q <= perr_f_d;
         ferr_f_q <= ferr_f_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         ferr_q   <= ferr_d;
         perr_q   <= perr_d;
         ovf_q    <= ovf_d;
      end
   end

`ifdef UART_RX_BREAK_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         par0_q  <= 1'b0;
         stop0_q <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         par0_q  <= par0_d;
         stop0_q <= stop0_d;
         brk_q   <= brk_d;
      end
   end
   assign brk = brk_q;
`else
   assign brk = 1'b0;
`endif

   assign rdata  = rdata_q;
   assign rvalid = rvalid_q;
   assign ferr   = ferr_q;
   assign perr   = perr_q;
   assign ovf    = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_cfg
// Purpose  : Self-checking bench for uart_rx_cfg. It drives an 8N1 instance and
//            an 8E1 instance. Expected words and flags come from a frame-level
//            model of the serial format.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_cfg;

   localparam int CPB = 16;
`ifdef UART_RX_BREAK_EN
   localparam bit BRK_EN = 1'b1;
`else
   localparam bit BRK_EN = 1'b0;
`endif

   logic       clk    = 1'b0;
   logic       rst    = 1'b1;
   logic       rxd_n  = 1'b1;
   logic       rxd_e  = 1'b1;
   logic       rready = 1'b0;
   logic [7:0] rdata_n, rdata_e;
   logic       rvalid_n, ferr_n, perr_n, ovf_n, brk_n;
   logic       rvalid_e, ferr_e, perr_e, ovf_e, brk_e;

   int n_vec = 0;
   int n_err = 0;

   // Accepted words, packed as {brk, ferr, perr, rdata}.
   logic [10:0] obs_n[$];
   logic [10:0] obs_e[$];

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut_n (
      .clk(clk), .rst(rst), .rxd(rxd_n), .rdata(rdata_n), .rvalid(rvalid_n),
      .rready(rready), .ferr(ferr_n), .perr(perr_n), .ovf(ovf_n), .brk(brk_n));

   uart_rx_cfg #(.CLK_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_dut_e (
      .clk(clk), .rst(rst), .rxd(rxd_e), .rdata(rdata_e), .rvalid(rvalid_e),
      .rready(rready), .ferr(ferr_e), .perr(perr_e), .ovf(ovf_e), .brk(brk_e));

   always @(negedge clk) begin
      if (!rst && rvalid_n && rready) obs_n.push_back({brk_n, ferr_n, perr_n, rdata_n});
      if (!rst && rvalid_e && rready) obs_e.push_back({brk_e, ferr_e, perr_e, rdata_e});
   end

   // Frame-level reference for one transmitted frame.
   function automatic logic [10:0] model(input bit e, input logic [7:0] d,
                                         input logic p, input logic s);
      logic b, fe, pe;
      b  = BRK_EN && (d == 8'h00) && (!e || p == 1'b0) && (s == 1'b0);
      fe = !s;
      pe = e ? ^{d, p} : 1'b0;   // even parity: total ones must be even
      return {b, fe, pe, d};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input bit e, input logic v, input bit glitch);
      for (int c = 0; c < CPB; c++) begin
         logic lv;
         lv = (glitch && c == 9) ? ~v : v;
         if (e) rxd_e = lv; else rxd_n = lv;
         cyc(1);
      end
   endtask

   // start, 8 data LSB first, [parity], stop, then two idle bit times
   task automatic send_frame(input bit e, input logic [7:0] d, input logic p,
                             input logic s, input int glitch_idx);
      drive_bit(e, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(e, d[i], i == glitch_idx);
      if (e) drive_bit(e, p, 1'b0);
      drive_bit(e, s, 1'b0);
      drive_bit(e, 1'b1, 1'b0);
      drive_bit(e, 1'b1, 1'b0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cyc(4);
      n_vec++;
      if ({rvalid_n, ferr_n, perr_n, ovf_n, brk_n, rdata_n} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_n: got %h want 0", {rvalid_n, ferr_n, perr_n, ovf_n, brk_n, rdata_n});
      end
      n_vec++;
      if ({rvalid_e, ferr_e, perr_e, ovf_e, brk_e, rdata_e} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_e: got %h want 0", {rvalid_e, ferr_e, perr_e, ovf_e, brk_e, rdata_e});
      end
      rst = 1'b0;
      cyc(4);
   endtask

   task automatic test_basic();
      obs_n.delete();
      rready = 1'b1;
      send_frame(1'b0, 8'hA5, 1'b0, 1'b1, -1);
      n_vec++;
      if (obs_n.size() != 1) begin
         n_err++;
         $display("FAIL basic_count: got %0d want 1", obs_n.size());
      end else begin
         n_vec++;
         if (obs_n[0] !== model(1'b0, 8'hA5, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL basic_word: got %h want %h", obs_n[0], model(1'b0, 8'hA5, 1'b0, 1'b1));
         end
      end
      n_vec++;
      if ({rvalid_n, ovf_n} !== 2'b00) begin
         n_err++;
         $display("FAIL basic_idle: got rvalid,ovf=%b want 00", {rvalid_n, ovf_n});
      end
   endtask

   task automatic test_false_start();
      obs_n.delete();
      rxd_n = 1'b0;
      cyc(3);
      rxd_n = 1'b1;
      cyc(3 * CPB);
      n_vec++;
      if (obs_n.size() != 0 || rvalid_n !== 1'b0) begin
         n_err++;
         $display("FAIL false_start: got %0d words rvalid=%b want 0 words", obs_n.size(), rvalid_n);
      end
      send_frame(1'b0, 8'h3C, 1'b0, 1'b1, -1);
      n_vec++;
      if (obs_n.size() != 1 || obs_n[0] !== model(1'b0, 8'h3C, 1'b0, 1'b1)) begin
         n_err++;
         $display("FAIL after_false_start: got %0d words first %h want 1 word %h",
                  obs_n.size(), obs_n[0], model(1'b0, 8'h3C, 1'b0, 1'b1));
      end
   endtask

   task automatic test_parity();
      obs_e.delete();
      rready = 1'b1;
      send_frame(1'b1, 8'h07, 1'b0, 1'b1, -1);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, -1);
      n_vec++;
      if (obs_e.size() != 2) begin
         n_err++;
         $display("FAIL parity_count: got %0d want 2", obs_e.size());
      end else begin
         n_vec++;
         if (obs_e[0] !== model(1'b1, 8'h07, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL parity_bad: got %h want %h", obs_e[0], model(1'b1, 8'h07, 1'b0, 1'b1));
         end
         n_vec++;
         if (obs_e[1] !== model(1'b1, 8'h07, 1'b1, 1'b1)) begin
            n_err++;
            $display("FAIL parity_good: got %h want %h", obs_e[1], model(1'b1, 8'h07, 1'b1, 1'b1));
         end
      end
   endtask

   task automatic test_ferr_glitch();
      obs_n.delete();
      rready = 1'b1;
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, -1);
      send_frame(1'b0, 8'h55, 1'b0, 1'b1, 3);
      n_vec++;
      if (obs_n.size() != 2) begin
         n_err++;
         $display("FAIL ferr_glitch_count: got %0d want 2", obs_n.size());
      end else begin
         n_vec++;
         if (obs_n[0] !== model(1'b0, 8'h55, 1'b0, 1'b0)) begin
            n_err++;
            $display("FAIL ferr_word: got %h want %h", obs_n[0], model(1'b0, 8'h55, 1'b0, 1'b0));
         end
         n_vec++;
         if (obs_n[1] !== model(1'b0, 8'h55, 1'b0, 1'b1)) begin
            n_err++;
            $display("FAIL glitch_word: got %h want %h", obs_n[1], model(1'b0, 8'h55, 1'b0, 1'b1));
         end
      end
   endtask

   task automatic test_overrun();
      obs_n.delete();
      rready = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b1, -1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b1, -1);
      n_vec++;
      if ({rvalid_n, ovf_n, rdata_n} !== {1'b1, 1'b1, 8'h11}) begin
         n_err++;
         $display("FAIL overrun_hold: got rvalid,ovf,rdata=%b,%b,%h want 1,1,11", rvalid_n, ovf_n, rdata_n);
      end
      rready = 1'b1;
      cyc(1);
      rready = 1'b0;
      n_vec++;
      if ({rvalid_n, ovf_n} !== 2'b00) begin
         n_err++;
         $display("FAIL overrun_clear: got rvalid,ovf=%b want 00", {rvalid_n, ovf_n});
      end
      n_vec++;
      if (obs_n.size() != 1 || obs_n[0] !== model(1'b0, 8'h11, 1'b0, 1'b1)) begin
         n_err++;
         $display("FAIL overrun_accepted: got %0d words first %h want 1 word 011", obs_n.size(), obs_n[0]);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] d;
      d = 8'hC3;
      obs_n.delete();
      rready = 1'b1;
      drive_bit(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i], 1'b0);
      rxd_n = d[4];
      cyc(CPB / 2);
      rst = 1'b1;
      cyc(2);
      n_vec++;
      if ({rvalid_n, ferr_n, perr_n, ovf_n, brk_n, rdata_n} !== 13'h0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %h want 0", {rvalid_n, ferr_n, perr_n, ovf_n, brk_n, rdata_n});
      end
      rxd_n = 1'b1;
      cyc(2);
      rst = 1'b0;
      cyc(3 * CPB);
      n_vec++;
      if (obs_n.size() != 0 || rvalid_n !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid_discard: got %0d words want 0", obs_n.size());
      end
      send_frame(1'b0, 8'h81, 1'b0, 1'b1, -1);
      n_vec++;
      if (obs_n.size() != 1 || obs_n[0] !== model(1'b0, 8'h81, 1'b0, 1'b1)) begin
         n_err++;
         $display("FAIL after_reset_mid: got %0d words first %h want 1 word 081", obs_n.size(), obs_n[0]);
      end
   endtask

   task automatic test_random();
      logic [10:0] exp_n[$];
      logic [10:0] exp_e[$];
      obs_n.delete();
      obs_e.delete();
      rready = 1'b1;
      for (int k = 0; k < 24; k++) begin
         bit         e;
         logic [7:0] d;
         logic       p, s;
         e = 1'($urandom_range(0, 1));
         d = 8'($urandom);
         if ($urandom_range(0, 7) == 0) d = 8'h00;
         p = ^d;
         if ($urandom_range(0, 2) == 0) p = ~p;
         s = ($urandom_range(0, 3) != 0);
         if (e) exp_e.push_back(model(e, d, p, s));
         else   exp_n.push_back(model(e, d, p, s));
         send_frame(e, d, p, s, -1);
      end
      n_vec++;
      if (obs_n.size() != exp_n.size() || obs_e.size() != exp_e.size()) begin
         n_err++;
         $display("FAIL random_count: got %0d/%0d want %0d/%0d",
                  obs_n.size(), obs_e.size(), exp_n.size(), exp_e.size());
      end
      for (int i = 0; i < exp_n.size() && i < obs_n.size(); i++) begin
         n_vec++;
         if (obs_n[i] !== exp_n[i]) begin
            n_err++;
            $display("FAIL random_n[%0d]: got %h want %h", i, obs_n[i], exp_n[i]);
         end
      end
      for (int i = 0; i < exp_e.size() && i < obs_e.size(); i++) begin
         n_vec++;
         if (obs_e[i] !== exp_e[i]) begin
            n_err++;
            $display("FAIL random_e[%0d]: got %h want %h", i, obs_e[i], exp_e[i]);
         end
      end
   endtask

   task automatic test_break();
      obs_n.delete();
      rready = 1'b1;
      rxd_n = 1'b0;
      cyc(30 * CPB);
      rxd_n = 1'b1;
      cyc(4 * CPB);
      n_vec++;
      if (BRK_EN ? (obs_n.size() != 1) : (obs_n.size() < 1)) begin
         n_err++;
         $display("FAIL break_count: got %0d words want %s", obs_n.size(), BRK_EN ? "1" : ">=1");
      end else begin
         n_vec++;
         if (obs_n[0] !== {BRK_EN, 1'b1, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL break_word: got %h want %h", obs_n[0], {BRK_EN, 1'b1, 1'b0, 8'h00});
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_false_start();
      test_parity();
      test_ferr_glitch();
      test_overrun();
      test_reset_mid();
      test_random();
      test_break();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
